// File: rtl/mem_stage_unit_if.sv
// EX/MEM packet, data-memory handshake and MEM/WB result bundle for mem_stage_unit.
// slave = the memory stage itself; master = whoever drives packets and services memory.
interface mem_stage_unit_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [75:0]       ex_mem_bus;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              wb_valid;
    logic              wb_en;
    logic [2:0]        wb_addr;
    logic [15:0]       wb_data;
    logic              pc_valid;
    logic [31:0]       pc_out;
    logic              flags_valid;
    logic [2:0]        flags_out;
    logic              mem_err;

    modport slave (
        input  in_valid, ex_mem_bus, mem_rdata, mem_ack,
        output stall, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_en, wb_addr, wb_data,
               pc_valid, pc_out, flags_valid, flags_out, mem_err
    );

    modport master (
        output in_valid, ex_mem_bus, mem_rdata, mem_ack,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_en, wb_addr, wb_data,
               pc_valid, pc_out, flags_valid, flags_out, mem_err
    );
endinterface

// File: rtl/mem_stage_unit.sv
// Memory stage: consumes EX/MEM packets, performs data-memory accesses (incl. PC/flag stack
// push/pop) and emits writeback/restore results. Optional ack watchdog: define MEM_TIMEOUT_EN.
module mem_stage_unit #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       pkt_data_s;
    logic [2:0]        pkt_wb_addr_s;
    logic              pkt_mr_s;
    logic              pkt_mw_s;
    logic              pkt_wb_s;
    logic [ADDR_W-1:0] pkt_addr_s;
    logic              pkt_jwsp_s;
    logic              pkt_spc_s;
    logic              pkt_sfl_s;
    logic [2:0]        pkt_flags_s;
    logic              pkt_unused_s;

    assign pkt_data_s    = bus.ex_mem_bus[31:0];
    assign pkt_wb_addr_s = bus.ex_mem_bus[34:32];
    assign pkt_mr_s      = bus.ex_mem_bus[35];
    assign pkt_mw_s      = bus.ex_mem_bus[36];
    assign pkt_wb_s      = bus.ex_mem_bus[37];
    assign pkt_addr_s    = bus.ex_mem_bus[38 +: ADDR_W];
    assign pkt_jwsp_s    = bus.ex_mem_bus[70];
    assign pkt_spc_s     = bus.ex_mem_bus[71];
    assign pkt_sfl_s     = bus.ex_mem_bus[72];
    assign pkt_flags_s   = bus.ex_mem_bus[75:73];
    assign pkt_unused_s  = ^bus.ex_mem_bus[69:38+ADDR_W];

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       hi_word_q, hi_word_d;
    logic              two_word_q, two_word_d;
    logic              stk_flags_q, stk_flags_d;
    logic              rd_wb_en_q, rd_wb_en_d;
    logic [2:0]        pend_wb_addr_q, pend_wb_addr_d;
    logic [2:0]        pend_flags_q, pend_flags_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [2:0]        wb_addr_q, wb_addr_d;
    logic [15:0]       wb_data_q, wb_data_d;
    logic              pc_valid_q, pc_valid_d;
    logic [31:0]       pc_out_q, pc_out_d;
    logic              flags_valid_q, flags_valid_d;
    logic [2:0]        flags_out_q, flags_out_d;
    logic              timeout_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    assign timeout_s = (state_q != IDLE) && !bus.mem_ack && (cnt_q == CNT_LAST);

    // Wait counter restarts at every sampled ack, so each access gets its own budget.
    always_comb begin
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q | timeout_s;
        if ((state_q == IDLE) || bus.mem_ack) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Watchdog registers; mem_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    logic timeout_unused_s;

    assign timeout_s        = 1'b0;
    assign timeout_unused_s = (TIMEOUT > 0);
    assign bus.mem_err      = 1'b0;
`endif

    // Next-state and result logic; result outputs hold, strobes default low.
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        hi_word_d      = hi_word_q;
        two_word_d     = two_word_q;
        stk_flags_d    = stk_flags_q;
        rd_wb_en_d     = rd_wb_en_q;
        pend_wb_addr_d = pend_wb_addr_q;
        pend_flags_d   = pend_flags_q;
        wb_valid_d     = 1'b0;
        wb_en_d        = wb_en_q;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        pc_valid_d     = 1'b0;
        pc_out_d       = pc_out_q;
        flags_valid_d  = 1'b0;
        flags_out_d    = flags_out_q;

        case (state_q)
            IDLE: begin
                if (!bus.in_valid) begin
                    state_d = IDLE;
                end else if (!pkt_mr_s && !pkt_mw_s) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = pkt_wb_s & ~pkt_jwsp_s;
                    wb_addr_d  = pkt_wb_addr_s;
                    wb_data_d  = pkt_data_s[15:0];
                end else begin
                    state_d        = ACC1;
                    mem_req_d      = 1'b1;
                    mem_we_d       = pkt_mw_s;
                    mem_addr_d     = pkt_addr_s;
                    mem_wdata_d    = (pkt_mw_s && pkt_sfl_s && !pkt_spc_s) ?
                                     {13'b0, pkt_flags_s} : pkt_data_s[15:0];
                    hi_word_d      = pkt_data_s[31:16];
                    two_word_d     = pkt_spc_s;
                    stk_flags_d    = pkt_sfl_s;
                    rd_wb_en_d     = pkt_mr_s & ~pkt_mw_s & ~pkt_spc_s & ~pkt_sfl_s &
                                     pkt_wb_s & ~pkt_jwsp_s;
                    pend_wb_addr_d = pkt_wb_addr_s;
                    pend_flags_d   = pkt_flags_s;
                end
            end
            ACC1, ACC2: begin
                if (timeout_s) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (!bus.mem_ack) begin
                    state_d = state_q;
                end else if ((state_q == ACC1) && two_word_q) begin
                    // Push grows the stack downward, pop walks back up.
                    state_d     = ACC2;
                    mem_addr_d  = mem_we_q ? (mem_addr_q - A_ONE) : (mem_addr_q + A_ONE);
                    mem_wdata_d = hi_word_q;
                    hi_word_d   = mem_we_q ? hi_word_q : bus.mem_rdata;
                end else begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_en_d    = rd_wb_en_q;
                    wb_addr_d  = pend_wb_addr_q;
                    if (mem_we_q) begin
                        wb_data_d = wb_data_q;
                    end else if (two_word_q) begin
                        pc_valid_d    = 1'b1;
                        pc_out_d      = {hi_word_q, bus.mem_rdata};
                        flags_valid_d = stk_flags_q;
                        flags_out_d   = stk_flags_q ? pend_flags_q : flags_out_q;
                    end else begin
                        wb_data_d     = bus.mem_rdata;
                        flags_valid_d = stk_flags_q;
                        flags_out_d   = stk_flags_q ? bus.mem_rdata[2:0] : flags_out_q;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 16'h0000;
            hi_word_q      <= 16'h0000;
            two_word_q     <= 1'b0;
            stk_flags_q    <= 1'b0;
            rd_wb_en_q     <= 1'b0;
            pend_wb_addr_q <= 3'd0;
            pend_flags_q   <= 3'd0;
            wb_valid_q     <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= 3'd0;
            wb_data_q      <= 16'h0000;
            pc_valid_q     <= 1'b0;
            pc_out_q       <= 32'h0000_0000;
            flags_valid_q  <= 1'b0;
            flags_out_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            hi_word_q      <= hi_word_d;
            two_word_q     <= two_word_d;
            stk_flags_q    <= stk_flags_d;
            rd_wb_en_q     <= rd_wb_en_d;
            pend_wb_addr_q <= pend_wb_addr_d;
            pend_flags_q   <= pend_flags_d;
            wb_valid_q     <= wb_valid_d;
            wb_en_q        <= wb_en_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            pc_valid_q     <= pc_valid_d;
            pc_out_q       <= pc_out_d;
            flags_valid_q  <= flags_valid_d;
            flags_out_q    <= flags_out_d;
        end
    end

    assign bus.stall       = (state_q != IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.flags_valid = flags_valid_q;
    assign bus.flags_out   = flags_out_q;
endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: bench-side memory with random ack latency and a
// packet-level reference model of the expected access sequence and results.
`timescale 1ns/1ps
module tb_mem_stage_unit;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic exp_err = 1'b0;
    logic [15:0] mem_model [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    mem_stage_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_stage_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [75:0] mk_pkt(input logic [2:0] ff, input logic sfl, input logic spc,
                                           input logic jwsp, input logic [31:0] addr, input logic wb,
                                           input logic mw, input logic mr, input logic [2:0] wba,
                                           input logic [31:0] data);
        return {ff, sfl, spc, jwsp, addr, wb, mw, mr, wba, data};
    endfunction

    // Issue one packet from idle, service memory with 'dly' wait cycles per access, check all.
    task automatic send(input logic [75:0] pkt, input int dly, input string name);
        logic [ADDR_W-1:0] a, e_addr[2], g_addr[$], cur_addr;
        logic              e_we[2], g_we[$], cur_we;
        logic [15:0]       e_wd[2], g_wd[$], cur_wd;
        logic              mr, mw, spc, sfl, wb, jwsp, chk_wb, e_wb_en, e_pc_v, e_fl_v, done;
        logic [2:0]        ff, wba, e_fl, g_fl, g_wb_addr;
        logic [15:0]       e_wb_data, g_wb_data;
        logic [31:0]       d, e_pc, g_pc;
        logic              g_wb_en;
        int                e_n, wait_c, wbn, pcn, fln, stall_bad, stable_bad;
        d = pkt[31:0]; wba = pkt[34:32]; mr = pkt[35]; mw = pkt[36]; wb = pkt[37];
        a = pkt[38 +: ADDR_W]; jwsp = pkt[70]; spc = pkt[71]; sfl = pkt[72]; ff = pkt[75:73];
        e_n = 0; chk_wb = 1'b0; e_wb_en = 1'b0; e_pc_v = 1'b0; e_fl_v = 1'b0;
        e_wb_data = 16'h0; e_pc = 32'h0; e_fl = 3'd0;
        e_addr[0] = '0; e_addr[1] = '0; e_we[0] = 1'b0; e_we[1] = 1'b0; e_wd[0] = 16'h0; e_wd[1] = 16'h0;
        if (!mr && !mw) begin
            chk_wb = 1'b1; e_wb_en = wb && !jwsp; e_wb_data = d[15:0];
        end else if (mw) begin
            e_we[0] = 1'b1; e_we[1] = 1'b1; e_addr[0] = a;
            if (spc) begin
                e_n = 2; e_wd[0] = d[15:0]; e_addr[1] = a - 1'b1; e_wd[1] = d[31:16];
            end else begin
                e_n = 1; e_wd[0] = sfl ? {13'b0, ff} : d[15:0];
            end
        end else begin
            e_addr[0] = a;
            if (spc) begin
                e_n = 2; e_addr[1] = a + 1'b1; e_pc_v = 1'b1;
                e_pc = {mem_model[e_addr[0]], mem_model[e_addr[1]]};
                e_fl_v = sfl; e_fl = ff;
            end else if (sfl) begin
                e_n = 1; e_fl_v = 1'b1; e_fl = mem_model[a][2:0];
            end else begin
                e_n = 1; chk_wb = 1'b1; e_wb_en = wb && !jwsp; e_wb_data = mem_model[a];
            end
        end

        @(negedge clk);
        bus.in_valid = 1'b1; bus.ex_mem_bus = pkt;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        done = 1'b0; wait_c = 0; wbn = 0; pcn = 0; fln = 0; stall_bad = 0; stable_bad = 0;
        g_wb_en = 1'b0; g_wb_addr = 3'd0; g_wb_data = 16'h0; g_pc = 32'h0; g_fl = 3'd0;
        cur_addr = '0; cur_we = 1'b0; cur_wd = 16'h0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0; bus.mem_rdata = 16'($urandom);
            if (bus.wb_valid) begin wbn++; g_wb_en = bus.wb_en; g_wb_addr = bus.wb_addr; g_wb_data = bus.wb_data; end
            if (bus.pc_valid) begin pcn++; g_pc = bus.pc_out; end
            if (bus.flags_valid) begin fln++; g_fl = bus.flags_out; end
            if (bus.wb_valid || bus.pc_valid || bus.flags_valid) done = 1'b1;
            if (bus.mem_req) begin
                if (!bus.stall) stall_bad++;
                if (wait_c == 0) begin
                    cur_addr = bus.mem_addr; cur_we = bus.mem_we; cur_wd = bus.mem_wdata;
                end else if (bus.mem_addr !== cur_addr || bus.mem_we !== cur_we || bus.mem_wdata !== cur_wd) begin
                    stable_bad++;
                end
                if (wait_c == dly) begin
                    bus.mem_ack = 1'b1; wait_c = 0;
                    g_addr.push_back(cur_addr); g_we.push_back(cur_we); g_wd.push_back(cur_wd);
                    if (cur_we) mem_model[cur_addr] = cur_wd;
                    else bus.mem_rdata = mem_model[cur_addr];
                end else begin
                    wait_c++;
                end
            end
        end

        total++; if (!done) begin bad++; $display("FAIL %s done: no result pulse within 200 cycles", name); end
        total++; if (g_addr.size() != e_n) begin bad++; $display("FAIL %s access_count: got %0d want %0d", name, g_addr.size(), e_n); end
        for (int i = 0; i < e_n && i < g_addr.size(); i++) begin
            total++;
            if (g_addr[i] !== e_addr[i] || g_we[i] !== e_we[i] || (e_we[i] && g_wd[i] !== e_wd[i])) begin
                bad++;
                $display("FAIL %s access%0d: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                         name, i, g_addr[i], g_we[i], g_wd[i], e_addr[i], e_we[i], e_wd[i]);
            end
        end
        total++; if (stall_bad != 0 || stable_bad != 0) begin bad++; $display("FAIL %s stall_stable: got stall_bad=%0d stable_bad=%0d want 0 0", name, stall_bad, stable_bad); end
        total++; if (wbn != 1 || (!chk_wb && g_wb_en !== 1'b0)) begin bad++; $display("FAIL %s wb_pulse: got n=%0d en=%b want n=1 en=0", name, wbn, g_wb_en); end
        if (chk_wb) begin
            total++;
            if (g_wb_en !== e_wb_en || g_wb_addr !== wba || g_wb_data !== e_wb_data) begin
                bad++;
                $display("FAIL %s wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                         name, g_wb_en, g_wb_addr, g_wb_data, e_wb_en, wba, e_wb_data);
            end
        end
        total++; if (pcn != int'(e_pc_v) || (e_pc_v && g_pc !== e_pc)) begin bad++; $display("FAIL %s pc: got n=%0d pc=%h want n=%0d pc=%h", name, pcn, g_pc, e_pc_v, e_pc); end
        total++; if (fln != int'(e_fl_v) || (e_fl_v && g_fl !== e_fl)) begin bad++; $display("FAIL %s flags: got n=%0d fl=%b want n=%0d fl=%b", name, fln, g_fl, e_fl_v, e_fl); end
        @(negedge clk);
        total++;
        if (bus.wb_valid !== 1'b0 || bus.pc_valid !== 1'b0 || bus.flags_valid !== 1'b0 || bus.stall !== 1'b0 || bus.mem_err !== exp_err) begin
            bad++;
            $display("FAIL %s after: got wbv=%b pcv=%b flv=%b stall=%b err=%b want 0 0 0 0 %b",
                     name, bus.wb_valid, bus.pc_valid, bus.flags_valid, bus.stall, bus.mem_err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0 || bus.pc_valid !== 1'b0 ||
            bus.flags_valid !== 1'b0 || bus.mem_err !== 1'b0 || bus.wb_data !== 16'h0 || bus.pc_out !== 32'h0 ||
            bus.wb_en !== 1'b0 || bus.flags_out !== 3'd0 || bus.mem_addr !== 12'h0) begin
            bad++;
            $display("FAIL reset: got stall=%b req=%b wbv=%b wbd=%h pc=%h err=%b want all 0",
                     bus.stall, bus.mem_req, bus.wb_valid, bus.wb_data, bus.pc_out, bus.mem_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0000_0037), 0, "pass");
        send(mk_pkt(3'd5, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h1234_BEEF), 0, "pass_jwsp");
    endtask

    task automatic test_store_load();
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_00AB), 5, "store");
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0), 5, "load");
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_F010, 1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_5555), 1, "mr_mw_both");
    endtask

    task automatic test_pc_stack();
        send(mk_pkt(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_03FF, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0001_0F0F), 2, "pc_push");
        send(mk_pkt(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_03FE, 1'b1, 1'b0, 1'b1, 3'd4, 32'h0), 0, "pc_pop");
        send(mk_pkt(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 3'd0, 32'hCAFE_F00D), 1, "pc_push_wrap");
        send(mk_pkt(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0), 0, "pc_pop_wrap");
    endtask

    task automatic test_flags_stack();
        send(mk_pkt(3'b101, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF), 0, "fl_push");
        send(mk_pkt(3'b010, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0), 3, "fl_pop");
        send(mk_pkt(3'b110, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0), 1, "pc_fl_pop");
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        total++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.pc_valid !== 1'b0 || bus.flags_valid !== 1'b0) begin
            bad++;
            $display("FAIL ack_idle: got req=%b stall=%b wbv=%b pcv=%b flv=%b want 0", bus.mem_req, bus.stall, bus.wb_valid, bus.pc_valid, bus.flags_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [75:0] pkt;
        logic [21:0] exp_v, got_v;
        exp_v = 22'h0;
        @(negedge clk);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                got_v = {bus.wb_valid, bus.wb_en, bus.wb_addr, bus.wb_data, bus.stall};
                total++;
                if (got_v !== exp_v) begin bad++; $display("FAIL b2b%0d: got %h want %h", i, got_v, exp_v); end
            end
            if (i < 8) begin
                pkt = mk_pkt(3'($urandom), 1'($urandom), 1'b0, 1'($urandom), $urandom, 1'($urandom),
                             1'b0, 1'b0, 3'($urandom), $urandom);
                exp_v = {1'b1, pkt[37] & ~pkt[70], pkt[34:32], pkt[15:0], 1'b0};
                bus.in_valid = 1'b1; bus.ex_mem_bus = pkt;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got wbv=%b want 0", bus.wb_valid); end
    endtask

    task automatic test_random();
        logic [75:0] pkt;
        logic mr, mw, spc, sfl;
        for (int i = 0; i < 40; i++) begin
            mr = 1'b0; mw = 1'b0; spc = 1'b0; sfl = 1'b0;
            case ($urandom_range(0, 7))
                0: begin end
                1: mw = 1'b1;
                2: begin mw = 1'b1; spc = 1'b1; end
                3: begin mw = 1'b1; sfl = 1'b1; end
                4: mr = 1'b1;
                5: begin mr = 1'b1; spc = 1'b1; sfl = 1'($urandom); end
                6: begin mr = 1'b1; sfl = 1'b1; end
                default: begin mr = 1'b1; mw = 1'b1; end
            endcase
            pkt = mk_pkt(3'($urandom), sfl, spc, ($urandom_range(0, 4) == 0), $urandom, 1'($urandom),
                         mw, mr, 3'($urandom), $urandom);
            send(pkt, $urandom_range(0, 4), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        int pcn;
        pcn = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ex_mem_bus = mk_pkt(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        total++; if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1) begin bad++; $display("FAIL rst_mid_acc2: got req=%b stall=%b want 1 1", bus.mem_req, bus.stall); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_drop: got req=%b stall=%b want 0 0", bus.mem_req, bus.stall); end
        repeat (2) begin @(negedge clk); if (bus.pc_valid) pcn++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.pc_valid || bus.wb_valid) pcn++; end
        total++; if (pcn != 0) begin bad++; $display("FAIL rst_mid_pulse: got %0d pulses want 0", pcn); end
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd5, 32'h0000_7777), 0, "rst_mid_after");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int reqc, pulses;
        reqc = 0; pulses = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ex_mem_bus = mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) reqc++;
            if (bus.wb_valid || bus.pc_valid || bus.flags_valid) pulses++;
        end
        total++;
        if (reqc != TIMEOUT || pulses != 0 || bus.stall !== 1'b0 || bus.mem_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout: got req_cycles=%0d pulses=%0d stall=%b err=%b want %0d 0 0 1", reqc, pulses, bus.stall, bus.mem_err, TIMEOUT);
        end
        exp_err = 1'b1;
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0000_0099), 0, "timeout_sticky");
    endtask
`else
    task automatic test_timeout();
        send(mk_pkt(3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0), 40, "long_wait");
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.ex_mem_bus = 76'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = 16'($urandom);
        test_reset();
        test_passthrough();
        test_store_load();
        test_pc_stack();
        test_flags_stack();
        test_ack_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
